// File: rtl/disp_ram_arbiter_if.sv
// Requester, read-return and RAM-side signals of the display RAM scheduler.
interface disp_ram_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
);
   logic              cap_wr_valid;
   logic [ADDR_W-1:0] cap_wr_addr;
   logic [DATA_W-1:0] cap_wr_data;
   logic              line_req;
   logic [7:0]        line_num;
   logic              line_busy;
   logic              line_rd_valid;
   logic [5:0]        line_rd_idx;
   logic [DATA_W-1:0] line_rd_data;
   logic              line_done;
   logic              ss_req_valid;
   logic [ADDR_W-1:0] ss_req_addr;
   logic              ss_req_ready;
   logic              ss_rd_valid;
   logic [DATA_W-1:0] ss_rd_data;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_q;

   modport master (
      output cap_wr_valid, cap_wr_addr, cap_wr_data, line_req, line_num,
             ss_req_valid, ss_req_addr, ram_q,
      input  line_busy, line_rd_valid, line_rd_idx, line_rd_data, line_done,
             ss_req_ready, ss_rd_valid, ss_rd_data, ram_addr, ram_data, ram_wren
   );

   modport slave (
      input  cap_wr_valid, cap_wr_addr, cap_wr_data, line_req, line_num,
             ss_req_valid, ss_req_addr, ram_q,
      output line_busy, line_rd_valid, line_rd_idx, line_rd_data, line_done,
             ss_req_ready, ss_rd_valid, ss_rd_data, ram_addr, ram_data, ram_wren
   );
endinterface

// File: rtl/disp_ram_arbiter.sv
// Single-port display RAM scheduler: capture FIFO, line prefetch and screenshot reads.
// ram_* one cycle after grant, read data 1+RD_LAT cycles after grant; only screenshots see backpressure.
module disp_ram_arbiter #(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 8,
   parameter int LINE_BYTES = 40,
   parameter int LINES      = 144,
   parameter int CAP_DEPTH  = 4,
   parameter int RD_LAT     = 1
) (
   input logic               pixel_clk,
   input logic               rst,
   disp_ram_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(CAP_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CAP_FULL = CNT_W'(CAP_DEPTH);
   localparam logic [5:0]       LAST_IDX = 6'(LINE_BYTES - 1);
   localparam logic [7:0]       LINE_LIM = 8'(LINES);
   localparam logic [0:0]       IDLE     = 1'b0;
   localparam logic [0:0]       FETCH    = 1'b1;

   logic [ADDR_W-1:0] fifo_addr [CAP_DEPTH];
   logic [DATA_W-1:0] fifo_data [CAP_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              fifo_full, fifo_empty;

   logic [0:0]        state;
   logic [ADDR_W-1:0] base;
   logic [5:0]        idx;
   logic              issued_all;
   logic              fetch_issue;

   logic              gnt_cap, gnt_line, gnt_ss;

   logic              tag_vld  [RD_LAT+1];
   logic              tag_ss   [RD_LAT+1];
   logic              tag_last [RD_LAT+1];
   logic [5:0]        tag_idx  [RD_LAT+1];

   logic [ADDR_W-1:0] ram_addr_r;
   logic [DATA_W-1:0] ram_data_r;
   logic              ram_wren_r;
   logic              line_vld, ss_vld, line_done_i;

   assign fifo_full   = (fifo_cnt == CAP_FULL);
   assign fifo_empty  = (fifo_cnt == '0);
   assign fetch_issue = (state == FETCH) && !issued_all;

   // A full FIFO must drain this cycle: the capture side cannot be stalled.
   assign gnt_cap  = fifo_full || (!fetch_issue && !fifo_empty);
   assign gnt_line = fetch_issue && !fifo_full;
   assign gnt_ss   = bus.ss_req_valid && !rst && !gnt_cap && !gnt_line;

   always_ff @(posedge pixel_clk) begin
      if (bus.cap_wr_valid) begin
         fifo_addr[wr_ptr] <= bus.cap_wr_addr;
         fifo_data[wr_ptr] <= bus.cap_wr_data;
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
         state      <= IDLE;
         base       <= '0;
         idx        <= '0;
         issued_all <= 1'b0;
         ram_addr_r <= '0;
         ram_data_r <= '0;
         ram_wren_r <= 1'b0;
      end else begin
         if (bus.cap_wr_valid) wr_ptr <= wr_ptr + PTR_W'(1);
         if (gnt_cap)          rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_cnt <= fifo_cnt + CNT_W'(bus.cap_wr_valid) - CNT_W'(gnt_cap);

         ram_wren_r <= gnt_cap;
         if (gnt_cap) begin
            ram_addr_r <= fifo_addr[rd_ptr];
            ram_data_r <= fifo_data[rd_ptr];
         end else if (gnt_line) begin
            ram_addr_r <= base + ADDR_W'(idx);
         end else if (gnt_ss) begin
            ram_addr_r <= bus.ss_req_addr;
         end

         case (state)
            IDLE: begin
               if (bus.line_req && (bus.line_num < LINE_LIM)) begin
                  state      <= FETCH;
                  base       <= ADDR_W'(bus.line_num) * ADDR_W'(LINE_BYTES);
                  idx        <= '0;
                  issued_all <= 1'b0;
               end
            end
            FETCH: begin
               if (gnt_line) begin
                  idx <= idx + 6'd1;
                  if (idx == LAST_IDX) issued_all <= 1'b1;
               end
               // Busy stays up until the last byte has actually been returned.
               if (line_done_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         for (int k = 0; k <= RD_LAT; k++) begin
            tag_vld[k]  <= 1'b0;
            tag_ss[k]   <= 1'b0;
            tag_last[k] <= 1'b0;
            tag_idx[k]  <= '0;
         end
      end else begin
         tag_vld[0]  <= gnt_line || gnt_ss;
         tag_ss[0]   <= gnt_ss;
         tag_last[0] <= gnt_line && (idx == LAST_IDX);
         tag_idx[0]  <= gnt_line ? idx : 6'd0;
         for (int k = 1; k <= RD_LAT; k++) begin
            tag_vld[k]  <= tag_vld[k-1];
            tag_ss[k]   <= tag_ss[k-1];
            tag_last[k] <= tag_last[k-1];
            tag_idx[k]  <= tag_idx[k-1];
         end
      end
   end

   assign line_vld    = tag_vld[RD_LAT] && !tag_ss[RD_LAT];
   assign ss_vld      = tag_vld[RD_LAT] && tag_ss[RD_LAT];
   assign line_done_i = line_vld && tag_last[RD_LAT];

   assign bus.line_busy     = (state == FETCH);
   assign bus.line_rd_valid = line_vld;
   assign bus.line_rd_idx   = line_vld ? tag_idx[RD_LAT] : 6'd0;
   assign bus.line_rd_data  = line_vld ? bus.ram_q : '0;
   assign bus.line_done     = line_done_i;
   assign bus.ss_req_ready  = gnt_ss;
   assign bus.ss_rd_valid   = ss_vld;
   assign bus.ss_rd_data    = ss_vld ? bus.ram_q : '0;
   assign bus.ram_addr      = ram_addr_r;
   assign bus.ram_data      = ram_data_r;
   assign bus.ram_wren      = ram_wren_r;
endmodule
